// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit ripple-carry
// slice over WIDTH/4 clock cycles, with valid/ready handshakes on both sides.
// The rca slice is kept in this file so the block elaborates on its own.

module rca (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [4:0] c;

    // Bit-by-bit ripple of the carry through the 4-bit slice.
    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = c_i;
        for (int i = 0; i < 4; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
            c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        c_o = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       sl_s;
    logic             sl_c;
    logic             last;
    logic [WIDTH-1:0] assembled;

    rca u_rca (
        .a_i (a_sh_q[3:0]),
        .b_i (b_sh_q[3:0]),
        .c_i (carry_q),
        .s_o (sl_s),
        .c_o (sl_c)
    );

    // The slice sum enters at the top, so after N shifts slice 0 sits at the bottom.
    assign last      = (idx_q == IW'(N - 1));
    assign assembled = {sl_s, res_sh_q[WIDTH-1:4]};

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

    // Next-state, handshake outputs and datapath next values.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_sh_d  = res_sh_q;
        carry_d   = carry_q;
        amsb_d    = amsb_q;
        bmsb_d    = bmsb_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                // in_ready is forced low while reset is held.
                in_ready = rst_n;
                if (in_valid) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    idx_d   = '0;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 4;
                b_sh_d   = b_sh_q >> 4;
                res_sh_d = assembled;
                carry_d  = sl_c;
                idx_d    = idx_q + IW'(1);
                if (last) begin
                    state_d = DONE;
                    idx_d   = '0;
                    sum_d   = assembled;
                    cout_d  = sl_c;
                    ovf_d   = (amsb_q == bmsb_q) & (assembled[WIDTH-1] != amsb_q);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand, partial-result and carry registers; always reloaded before use.
    always_ff @(posedge clk) begin
        a_sh_q   <= a_sh_d;
        b_sh_q   <= b_sh_d;
        res_sh_q <= res_sh_d;
        carry_q  <= carry_d;
        amsb_q   <= amsb_d;
        bmsb_q   <= bmsb_d;
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: a 16-bit instance driven from a vector table
// plus backpressure and mid-operation reset sequences, and an 8-bit instance.

module tb_nibble_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, cin, cout, overflow;
    logic [15:0] a, b, sum;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, overflow8;
    logic [7:0]  a8, b8, sum8;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    nibble_serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
        .overflow  (overflow8)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t        vt [8];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] prev_sum;
    logic        prev_co;
    logic        prev_ov;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full 16-bit operation with out_ready high: accept, 3 more RUN, DONE, IDLE.
    task automatic run16(input vec_t v, input string nm);
        chk({nm, " idle in_ready"}, 32'(in_ready), 32'd1);
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        cin      = 1'b1;
        chk({nm, " run in_ready"}, 32'(in_ready), 32'd0);
        chk({nm, " run sum held"}, 32'(sum), 32'(prev_sum));
        for (int i = 1; i < 4; i++) begin
            tick();
            chk({nm, " run out_valid"}, 32'(out_valid), 32'd0);
        end
        chk({nm, " run cout held"}, 32'(cout), 32'(prev_co));
        chk({nm, " run ovf held"}, 32'(overflow), 32'(prev_ov));
        tick();
        chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
        chk({nm, " sum"}, 32'(sum), 32'(v.s));
        chk({nm, " cout"}, 32'(cout), 32'(v.co));
        chk({nm, " overflow"}, 32'(overflow), 32'(v.ov));
        chk({nm, " done in_ready"}, 32'(in_ready), 32'd0);
        prev_sum = v.s;
        prev_co  = v.co;
        prev_ov  = v.ov;
        tick();
        chk({nm, " back idle out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, " back idle in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[4] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[5] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[6] = '{16'h89AB, 16'h7654, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[7] = '{16'hABCD, 16'h1357, 1'b0, 16'hBF24, 1'b0, 1'b0};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        a8         = '0;
        b8         = '0;
        cin8       = 1'b0;

        // Reset state.
        tick();
        tick();
        chk("reset in_ready low", 32'(in_ready), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("release in_ready", 32'(in_ready), 32'd1);
        prev_sum = '0;
        prev_co  = 1'b0;
        prev_ov  = 1'b0;

        // Table-driven operations.
        for (int i = 0; i < 8; i++) begin
            run16(vt[i], $sformatf("vec%0d", i));
        end

        // Backpressure: FFFF + 0000 + 1 held for several cycles with a competing operand.
        out_ready = 1'b0;
        a         = 16'hFFFF;
        b         = 16'h0000;
        cin       = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp out_valid", 32'(out_valid), 32'd1);
        chk("bp sum", 32'(sum), 32'h0000);
        chk("bp cout", 32'(cout), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 16'h1111;
            b        = 16'h2222;
            cin      = 1'b0;
            tick();
            chk("bp hold out_valid", 32'(out_valid), 32'd1);
            chk("bp hold sum", 32'(sum), 32'h0000);
            chk("bp hold cout", 32'(cout), 32'd1);
            chk("bp hold overflow", 32'(overflow), 32'd0);
            chk("bp hold in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp release out_valid", 32'(out_valid), 32'd0);
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp ignored in_ready", 32'(in_ready), 32'd1);
        chk("bp ignored sum", 32'(sum), 32'h0000);
        prev_sum = 16'h0000;
        prev_co  = 1'b1;
        prev_ov  = 1'b0;

        // Leave a nonzero result so the reset below is observable.
        run16(vt[0], "pre-reset");

        // Reset at slice index 2 of an operation that would set cout.
        a        = 16'hFFFF;
        b        = 16'h0001;
        cin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid-run reset in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort sum", 32'(sum), 32'd0);
        chk("abort cout", 32'(cout), 32'd0);
        chk("abort overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("abort release in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort no out_valid", 32'(out_valid), 32'd0);
        end
        prev_sum = '0;
        prev_co  = 1'b0;
        prev_ov  = 1'b0;
        run16(vt[5 - 0], "post-reset 4000+4000");
        run16('{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0}, "post-reset 0F0F+00F1");

        // 8-bit instance: A5 + 5B + 1 = 0x101, two slices.
        chk("w8 in_ready", 32'(in_ready8), 32'd1);
        a8        = 8'hA5;
        b8        = 8'h5B;
        cin8      = 1'b1;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        chk("w8 accept out_valid", 32'(out_valid8), 32'd0);
        tick();
        chk("w8 edge1 out_valid", 32'(out_valid8), 32'd0);
        tick();
        chk("w8 out_valid", 32'(out_valid8), 32'd1);
        chk("w8 sum", 32'(sum8), 32'h01);
        chk("w8 cout", 32'(cout8), 32'd1);
        chk("w8 overflow", 32'(overflow8), 32'd0);
        tick();
        chk("w8 back idle", 32'(in_ready8), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
